dma_transfer_sequencer: RTL and testbench

Sequencing controller for the DMA generator's address and word-count datapath. It loads a base address and transfer count, then steps the address counter up or down and the word counter down once per acknowledged bus transfer, the way the up/down counter slices are driven. It raises a request per transfer, handles abort, and reports completion and address wrap-around. It sits between the DMA register interface (start/config) and the bus/memory handshake.

---
 rtl/dma_transfer_sequencer.sv | 133 +++++++++++++
 tb/tb_dma_transfer_sequencer.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/dma_transfer_sequencer.sv
// dma_transfer_sequencer
//   Sequences the DMA generator's address and word-count datapath. An accepted
//   start loads a base address and a transfer count. The block then issues one
//   request per transfer. Each acknowledged transfer steps the address up or
//   down and counts the word counter down. The block also handles abort and
//   reports completion and address wrap-around.
//
// Ports
//   clk        rising-edge clock
//   res        asynchronous active-low reset
//   start      begin a block (sampled only in IDLE)
//   dir_up     1 = increment address, 0 = decrement (latched on start)
//   base_addr  first transfer address (latched on start)
//   word_cnt   number of transfers (latched on start)
//   ack        bus acknowledges the current transfer (sampled while req=1)
//   abort      terminate the block early (wins over a same-cycle ack)
//   req        transfer request at addr
//   addr       current transfer address
//   remaining  transfers still outstanding
//   busy       block in progress (LOAD or XFER)
//   done       one-cycle completion pulse
//   aborted    sticky: last block ended by abort
//   wrapped    sticky: address wrapped during last block
module dma_transfer_sequencer #(
  parameter int AW = 8,
  parameter int WW = 8
) (
  input  logic          clk,
  input  logic          res,
  input  logic          start,
  input  logic          dir_up,
  input  logic [AW-1:0] base_addr,
  input  logic [WW-1:0] word_cnt,
  input  logic          ack,
  input  logic          abort,
  output logic          req,
  output logic [AW-1:0] addr,
  output logic [WW-1:0] remaining,
  output logic          busy,
  output logic          done,
  output logic          aborted,
  output logic          wrapped
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_XFER = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]    state_q,   state_d;
  logic [AW-1:0] addr_q,    addr_d;
  logic [WW-1:0] rem_q,     rem_d;
  logic          dir_q,     dir_d;
  logic          aborted_q, aborted_d;
  logic          wrapped_q, wrapped_d;

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    rem_d     = rem_q;
    dir_d     = dir_q;
    aborted_d = aborted_q;
    wrapped_d = wrapped_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d   = S_LOAD;
          dir_d     = dir_up;
          addr_d    = base_addr;
          rem_d     = word_cnt;
          aborted_d = 1'b0;
          wrapped_d = 1'b0;
        end
      end
      S_LOAD: begin
        if (abort) begin
          state_d   = S_DONE;
          aborted_d = 1'b1;
        end else if (rem_q == '0) begin
          state_d = S_DONE;
        end else begin
          state_d = S_XFER;
        end
      end
      S_XFER: begin
        // abort takes precedence: a coincident ack leaves addr/remaining alone
        if (abort) begin
          state_d   = S_DONE;
          aborted_d = 1'b1;
        end else if (ack) begin
          if (dir_q) begin
            addr_d = addr_q + AW'(1);
            if (addr_q == '1) wrapped_d = 1'b1;
          end else begin
            addr_d = addr_q - AW'(1);
            if (addr_q == '0) wrapped_d = 1'b1;
          end
          rem_d = rem_q - WW'(1);
          if (rem_q == WW'(1)) state_d = S_DONE;
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      state_q   <= S_IDLE;
      addr_q    <= '0;
      rem_q     <= '0;
      dir_q     <= 1'b0;
      aborted_q <= 1'b0;
      wrapped_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      rem_q     <= rem_d;
      dir_q     <= dir_d;
      aborted_q <= aborted_d;
      wrapped_q <= wrapped_d;
    end
  end

  assign req       = (state_q == S_XFER);
  assign busy      = (state_q == S_LOAD) || (state_q == S_XFER);
  assign done      = (state_q == S_DONE);
  assign addr      = addr_q;
  assign remaining = rem_q;
  assign aborted   = aborted_q;
  assign wrapped   = wrapped_q;

endmodule

// File: tb/tb_dma_transfer_sequencer.sv
// Self-checking bench for dma_transfer_sequencer (AW=WW=8). Expected transfer
// addresses are queued when a block is started and popped as the DUT's
// requests are acknowledged; block-level results are fixed constants.
module tb_dma_transfer_sequencer;

  logic       clk;
  logic       res;
  logic       start;
  logic       dir_up;
  logic [7:0] base_addr;
  logic [7:0] word_cnt;
  logic       ack;
  logic       abort;
  logic       req;
  logic [7:0] addr;
  logic [7:0] remaining;
  logic       busy;
  logic       done;
  logic       aborted;
  logic       wrapped;

  int checks = 0;
  int failures = 0;
  logic [7:0] exp_q[$];

  dma_transfer_sequencer #(.AW(8), .WW(8)) dut (
    .clk       (clk),
    .res       (res),
    .start     (start),
    .dir_up    (dir_up),
    .base_addr (base_addr),
    .word_cnt  (word_cnt),
    .ack       (ack),
    .abort     (abort),
    .req       (req),
    .addr      (addr),
    .remaining (remaining),
    .busy      (busy),
    .done      (done),
    .aborted   (aborted),
    .wrapped   (wrapped)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_req"},     {31'd0, req},     32'd0);
    check({tag, "_busy"},    {31'd0, busy},    32'd0);
    check({tag, "_done"},    {31'd0, done},    32'd0);
    check({tag, "_aborted"}, {31'd0, aborted}, 32'd0);
    check({tag, "_wrapped"}, {31'd0, wrapped}, 32'd0);
    check({tag, "_addr"},    {24'd0, addr},    32'd0);
    check({tag, "_rem"},     {24'd0, remaining}, 32'd0);
  endtask

  // ack_mode: 0 = ack every req cycle, 1 = ack alternating 1/0.
  // abort_at: -1 none, -2 abort during LOAD, n>=0 abort (with ack) on transfer n.
  // rst_at:   -1 none, n>=0 assert reset once n transfers have been acked.
  task automatic run_block(input string tag, input logic [7:0] base, input logic [7:0] cnt,
                           input logic up, input int ack_mode, input int abort_at,
                           input bit glitch, input int rst_at,
                           input logic [7:0] f_addr, input logic [7:0] f_rem,
                           input logic f_abt, input logic f_wrp);
    int k;
    int xfers;
    int nreq;
    int phase;
    bit fin;
    logic a;
    logic [7:0] exp_rem;
    k = 0; xfers = 0; nreq = 0; phase = 0; fin = 0;
    exp_q.delete();
    @(negedge clk);
    start = 1'b1; dir_up = up; base_addr = base; word_cnt = cnt;
    for (int i = 0; i < int'(cnt); i++)
      exp_q.push_back(up ? base + 8'(i) : base - 8'(i));
    while (!fin && k < 100) begin
      @(negedge clk);
      k++;
      start = 1'b0;
      if (glitch) begin
        base_addr = 8'h99; word_cnt = 8'h07; dir_up = ~up;
      end
      if (k == 1) begin
        check({tag, "_load_busy"}, {31'd0, busy}, 32'd1);
        check({tag, "_load_req"},  {31'd0, req},  32'd0);
      end
      if (done) begin
        fin = 1;
        ack = 1'b0; abort = 1'b0;
        if (ack_mode == 0 && abort_at == -1)
          check({tag, "_done_cycle"}, k, int'(cnt) + 2);
        if (ack_mode == 0 && abort_at == -1)
          check({tag, "_nreq"}, nreq, int'(cnt));
        check({tag, "_fin_addr"},    {24'd0, addr},      {24'd0, f_addr});
        check({tag, "_fin_rem"},     {24'd0, remaining}, {24'd0, f_rem});
        check({tag, "_fin_aborted"}, {31'd0, aborted},   {31'd0, f_abt});
        check({tag, "_fin_wrapped"}, {31'd0, wrapped},   {31'd0, f_wrp});
        check({tag, "_done_busy"},   {31'd0, busy},      32'd0);
        check({tag, "_done_req"},    {31'd0, req},       32'd0);
        if (abort_at == -1) check({tag, "_q_empty"}, exp_q.size(), 0);
        @(negedge clk);
        check({tag, "_done_pulse"}, {31'd0, done}, 32'd0);
        check({tag, "_idle_busy"},  {31'd0, busy}, 32'd0);
        check({tag, "_hold_addr"},  {24'd0, addr}, {24'd0, f_addr});
        check({tag, "_hold_rem"},   {24'd0, remaining}, {24'd0, f_rem});
      end else if (req) begin
        nreq++;
        if (rst_at >= 0 && xfers == rst_at) begin
          ack = 1'b0; abort = 1'b0;
          res = 1'b0;
          #1;
          check_all_zero({tag, "_async_rst"});
          @(negedge clk);
          check_all_zero({tag, "_rst_held"});
          res = 1'b1;
          fin = 1;
        end else begin
          exp_rem = cnt - 8'(xfers);
          if (exp_q.size() > 0)
            check({tag, "_addr"}, {24'd0, addr}, {24'd0, exp_q[0]});
          else
            check({tag, "_unexpected_req"}, 32'd1, 32'd0);
          check({tag, "_rem"}, {24'd0, remaining}, {24'd0, exp_rem});
          a = (ack_mode == 0) ? 1'b1 : (phase % 2 == 0);
          phase++;
          start = glitch;
          if (abort_at >= 0 && xfers == abort_at && a) begin
            abort = 1'b1; ack = 1'b1;
          end else begin
            abort = 1'b0; ack = a;
            if (a) begin
              if (exp_q.size() > 0) void'(exp_q.pop_front());
              xfers++;
            end
          end
        end
      end else begin
        ack = 1'b0;
        abort = (abort_at == -2 && k == 1);
      end
    end
    if (!fin) check({tag, "_timeout"}, 32'd0, 32'd1);
    ack = 1'b0; abort = 1'b0; start = 1'b0;
  endtask

  initial begin
    res = 1'b0; start = 1'b0; dir_up = 1'b0; base_addr = '0; word_cnt = '0;
    ack = 1'b0; abort = 1'b0;
    @(negedge clk);
    check_all_zero("reset");
    @(negedge clk);
    res = 1'b1;

    run_block("up",      8'hFA, 8'd3, 1'b1, 0, -1, 1'b0, -1, 8'hFD, 8'd0, 1'b0, 1'b0);
    run_block("wrapdn",  8'h01, 8'd4, 1'b0, 1, -1, 1'b0, -1, 8'hFD, 8'd0, 1'b0, 1'b1);
    run_block("abort",   8'h10, 8'd5, 1'b1, 0,  1, 1'b0, -1, 8'h11, 8'd4, 1'b1, 1'b0);
    run_block("zero",    8'h33, 8'd0, 1'b1, 0, -1, 1'b0, -1, 8'h33, 8'd0, 1'b0, 1'b0);
    run_block("glitch",  8'h20, 8'd4, 1'b1, 0, -1, 1'b1, -1, 8'h24, 8'd0, 1'b0, 1'b0);
    run_block("wrapup",  8'hFE, 8'd3, 1'b1, 0, -1, 1'b0, -1, 8'h01, 8'd0, 1'b0, 1'b1);
    run_block("ldabort", 8'h55, 8'd6, 1'b0, 0, -2, 1'b0, -1, 8'h55, 8'd6, 1'b1, 1'b0);
    run_block("midrst",  8'h40, 8'd8, 1'b1, 0, -1, 1'b0,  2, 8'h00, 8'd0, 1'b0, 1'b0);
    run_block("postrst", 8'h80, 8'd5, 1'b0, 0, -1, 1'b0, -1, 8'h7B, 8'd0, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
